ds3231_i2c_target: RTL and testbench

//  I2C target (responder) that emulates the DS3231 RTC register file at 7-bit address DEV_ADDR.
//  It is the far end of our I2C master write/read path and the board-level bus model for it.
//  SCL/SDA are oversampled on the system clock. The target decodes START/STOP, address, register pointer and data.
//  SDA is open-drain: the block only pulls low, through sda_oe.

---
 rtl/ds3231_i2c_target.sv | 208 ++++++++++++++++++++
 tb/tb_ds3231_i2c_target.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ds3231_i2c_target.sv
// I2C target emulating the DS3231 register file: oversampled SCL/SDA, START/STOP
// decode, pointer/data handling, open-drain SDA through sda_oe, local update port.
module ds3231_i2c_target #(
    parameter logic [6:0] DEV_ADDR = 7'h68,
    parameter int         NREG     = 19,
    parameter int         FILT     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic       upd_we,
    input  logic [4:0] upd_addr,
    input  logic [7:0] upd_dat,
    output logic       wr_stb,
    output logic [4:0] wr_addr,
    output logic [7:0] wr_dat,
    output logic       busy
);

    localparam int NLINE = 2;  // line 0 = SCL, line 1 = SDA

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT
    } state_t;

    logic [NLINE-1:0] pins, filt, prev;

    assign pins = {sda_in, scl_in};

    // Each line: 2-FF synchronizer, then the level is accepted once the last FILT
    // synchronized samples agree; prev holds the previous filtered level for edge detect.
    for (genvar i = 0; i < NLINE; i++) begin : g_line
        logic [1:0]      sync_q;
        logic [FILT-2:0] hist;
        logic [FILT-1:0] win;
        logic            filt_q, prev_q;

        assign win     = {hist, sync_q[1]};
        assign filt[i] = filt_q;
        assign prev[i] = prev_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q <= '1;
                hist   <= '1;
                filt_q <= 1'b1;
                prev_q <= 1'b1;
            end else begin
                sync_q <= {sync_q[0], pins[i]};
                hist   <= win[FILT-2:0];
                if (win == '0)      filt_q <= 1'b0;
                else if (win == '1) filt_q <= 1'b1;
                prev_q <= filt_q;
            end
        end
    end

    logic scl_rise, scl_fall, start_c, stop_c, sda_f;

    assign sda_f    = filt[1];
    assign scl_rise =  filt[0] & ~prev[0];
    assign scl_fall = ~filt[0] &  prev[0];
    assign start_c  =  filt[0] & prev[0] &  prev[1] & ~filt[1];
    assign stop_c   =  filt[0] & prev[0] & ~prev[1] &  filt[1];

    state_t              state;
    logic [3:0]          bit_cnt;
    logic [7:0]          shreg;
    logic [4:0]          ptr;
    logic [NREG-1:0][7:0] regs;
    logic                sda_oe_q, rw, mack;
    logic [7:0]          byte_in;
    logic [4:0]          ptr_nxt;

    assign byte_in = {shreg[6:0], sda_f};
    assign ptr_nxt = (ptr == 5'(NREG - 1)) ? 5'd0 : ptr + 5'd1;

    // Reset must release SDA in the very clock it is asserted, not one later.
    assign sda_oe = sda_oe_q & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            ptr      <= '0;
            regs     <= '0;
            sda_oe_q <= 1'b0;
            rw       <= 1'b0;
            mack     <= 1'b0;
            wr_stb   <= 1'b0;
            wr_addr  <= '0;
            wr_dat   <= '0;
            busy     <= 1'b0;
        end else begin
            wr_stb <= 1'b0;
            // Local write first: a bus write to the same register later in this block overrides it.
            if (upd_we && upd_addr < 5'(NREG)) regs[upd_addr] <= upd_dat;

            if (stop_c) begin
                state    <= IDLE;
                sda_oe_q <= 1'b0;
                busy     <= 1'b0;
            end else if (start_c) begin
                state    <= ADDR;
                bit_cnt  <= '0;
                sda_oe_q <= 1'b0;
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        shreg   <= byte_in;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            if (byte_in[7:1] == DEV_ADDR && byte_in[7:1] != 7'd0) begin
                                state <= ADDR_ACK;
                                busy  <= 1'b1;
                                rw    <= byte_in[0];
                            end else begin
                                state <= WAIT;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    PTR: if (scl_rise) begin
                        shreg   <= byte_in;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            ptr   <= (byte_in < 8'(NREG)) ? byte_in[4:0] : 5'd0;
                            state <= PTR_ACK;
                        end
                    end
                    WDATA: if (scl_rise) begin
                        shreg   <= byte_in;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            regs[ptr] <= byte_in;
                            wr_stb    <= 1'b1;
                            wr_addr   <= ptr;
                            wr_dat    <= byte_in;
                            ptr       <= ptr_nxt;
                            state     <= WDATA_ACK;
                        end
                    end
                    // bit_cnt 8: between the 8th rise and the 9th rise; 9: during the 9th clock
                    ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                        if (scl_rise) begin
                            bit_cnt <= 4'd9;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe_q <= 1'b1;
                            end else begin
                                bit_cnt <= '0;
                                if (state == ADDR_ACK && rw) begin
                                    state    <= RDATA;
                                    shreg    <= regs[ptr];
                                    sda_oe_q <= ~regs[ptr][7];
                                end else begin
                                    sda_oe_q <= 1'b0;
                                    state    <= (state == ADDR_ACK) ? PTR : WDATA;
                                end
                            end
                        end
                    end
                    RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                state <= RDATA_ACK;
                                ptr   <= ptr_nxt;
                            end
                        end else if (scl_fall) begin
                            sda_oe_q <= ~shreg[6];
                            shreg    <= {shreg[6:0], 1'b0};
                        end
                    end
                    RDATA_ACK: begin
                        if (scl_rise) begin
                            bit_cnt <= 4'd9;
                            mack    <= ~sda_f;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe_q <= 1'b0;
                            end else if (mack) begin
                                bit_cnt  <= '0;
                                state    <= RDATA;
                                shreg    <= regs[ptr];
                                sda_oe_q <= ~regs[ptr][7];
                            end else begin
                                state    <= WAIT;
                                busy     <= 1'b0;
                                sda_oe_q <= 1'b0;
                            end
                        end
                    end
                    WAIT: begin
                        sda_oe_q <= 1'b0;
                        busy     <= 1'b0;
                    end
                    IDLE:    sda_oe_q <= 1'b0;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ds3231_i2c_target.sv
// Bench for ds3231_i2c_target: bit-banged I2C master, expected responses queued at
// stimulus time and compared by monitor processes as the DUT produces them.
module tb_ds3231_i2c_target;

    localparam int Q = 10;  // quarter SCL period in clk cycles

    logic       clk = 1'b0, rst = 1'b1, scl = 1'b1, sda_m = 1'b1;
    logic       upd_we = 1'b0;
    logic [4:0] upd_addr = '0;
    logic [7:0] upd_dat = '0;
    logic       sda_oe, wr_stb, busy, sda_line;
    logic [4:0] wr_addr;
    logic [7:0] wr_dat;

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    ds3231_i2c_target dut (
        .clk(clk), .rst(rst), .scl_in(scl), .sda_in(sda_line), .sda_oe(sda_oe),
        .upd_we(upd_we), .upd_addr(upd_addr), .upd_dat(upd_dat),
        .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_dat(wr_dat), .busy(busy)
    );

    typedef struct { string name; int val; } item_t;
    item_t exp_q[$], act_q[$];
    int    exp_wr[$];
    int    n_checks = 0, n_err = 0;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endfunction

    // Register-write monitor
    always @(negedge clk) begin
        int e;
        if (wr_stb) begin
            if (exp_wr.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_wr_stb: got addr %0d dat %0h, required no strobe", wr_addr, wr_dat);
            end else begin
                e = exp_wr.pop_front();
                check("wr_addr", int'(wr_addr), e >> 8);
                check("wr_dat", int'(wr_dat), e & 255);
            end
        end
    end

    // Bus-response monitor: ACK bits and read bytes seen by the master
    always @(negedge clk) begin
        item_t a, e;
        while (act_q.size() > 0) begin
            a = act_q.pop_front();
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_%s: got %0h, required nothing", a.name, a.val);
            end else begin
                e = exp_q.pop_front();
                check(e.name, a.val, e.val);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic w(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; w(Q); scl = 1'b1; w(2*Q); sda_m = 1'b0; w(2*Q); scl = 1'b0; w(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; w(Q); scl = 1'b1; w(2*Q); sda_m = 1'b1; w(2*Q);
    endtask

    task automatic i2c_bit(input logic b, output logic r);
        sda_m = b; w(Q); scl = 1'b1; w(Q); r = sda_line; w(Q); scl = 1'b0; w(Q);
    endtask

    task automatic push_exp(input string name, input int val);
        item_t it;
        it.name = name;
        it.val  = val;
        exp_q.push_back(it);
    endtask

    task automatic push_act(input string name, input int val);
        item_t it;
        it.name = name;
        it.val  = val;
        act_q.push_back(it);
    endtask

    task automatic wr(input logic [7:0] b, input int exp_ack, input string name);
        logic r;
        push_exp(name, exp_ack);
        for (int i = 7; i >= 0; i--) i2c_bit(b[i], r);
        i2c_bit(1'b1, r);
        push_act(name, int'(!r));
    endtask

    task automatic rd(input logic ack, input int exp_b, input string name);
        logic r;
        logic [7:0] d;
        d = '0;
        push_exp(name, exp_b);
        for (int i = 0; i < 8; i++) begin
            i2c_bit(1'b1, r);
            d = {d[6:0], r};
        end
        i2c_bit(!ack, r);
        push_act(name, int'(d));
    endtask

    initial begin
        logic r;
        int   seen;

        // reset state
        w(5);
        rst = 1'b0;
        w(2);
        check("rst_sda_oe", int'(sda_oe), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_wr_stb", int'(wr_stb), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_wr_dat", int'(wr_dat), 0);

        // 1) write three registers from pointer 0
        exp_wr.push_back(16'h0012); exp_wr.push_back(16'h0134); exp_wr.push_back(16'h0256);
        i2c_start();
        wr(8'hD0, 1, "t1_addr_ack");
        check("t1_busy", int'(busy), 1);
        wr(8'h00, 1, "t1_ptr_ack");
        wr(8'h12, 1, "t1_d0_ack");
        wr(8'h34, 1, "t1_d1_ack");
        wr(8'h56, 1, "t1_d2_ack");
        i2c_stop();
        w(5);
        check("t1_busy_after_stop", int'(busy), 0);
        // pointer kept at 3 across STOP: current-address read returns reg3
        i2c_start();
        wr(8'hD1, 1, "t1_rd_addr_ack");
        rd(1'b0, 8'h00, "t1_ptr3_read");
        i2c_stop();

        // 2) set pointer, repeated START, sequential read
        i2c_start();
        wr(8'hD0, 1, "t2_addr_ack");
        wr(8'h00, 1, "t2_ptr_ack");
        i2c_start();
        wr(8'hD1, 1, "t2_rd_addr_ack");
        rd(1'b1, 8'h12, "t2_rd0");
        rd(1'b1, 8'h34, "t2_rd1");
        rd(1'b0, 8'h56, "t2_rd2");
        w(4);
        check("t2_sda_oe_after_nack", int'(sda_oe), 0);
        check("t2_busy_after_nack", int'(busy), 0);
        i2c_stop();

        // 3) address mismatch, then a later START to our address; 4) pointer wrap
        exp_wr.push_back(16'h12AA); exp_wr.push_back(16'h00BB);
        i2c_start();
        wr(8'hA0, 0, "t3_mismatch_nack");
        check("t3_busy", int'(busy), 0);
        wr(8'h55, 0, "t3_ignored_nack");
        i2c_start();
        wr(8'hD0, 1, "t3_addr_ack");
        wr(8'h12, 1, "t4_ptr_ack");
        wr(8'hAA, 1, "t4_d0_ack");
        wr(8'hBB, 1, "t4_d1_ack");
        i2c_stop();
        i2c_start();
        wr(8'hD0, 1, "t4_addr_ack");
        wr(8'h40, 1, "t4_ptr40_ack");
        i2c_start();
        wr(8'hD1, 1, "t4_rd_addr_ack");
        rd(1'b0, 8'hBB, "t4_ptr40_reads_reg0");
        i2c_stop();
        i2c_start();
        wr(8'hD0, 1, "t4b_addr_ack");
        wr(8'h12, 1, "t4b_ptr_ack");
        i2c_start();
        wr(8'hD1, 1, "t4b_rd_addr_ack");
        rd(1'b1, 8'hAA, "t4b_reg18");
        rd(1'b0, 8'hBB, "t4b_wrap_reg0");
        i2c_stop();

        // 5) STOP partway through a data byte
        i2c_start();
        wr(8'hD0, 1, "t5_addr_ack");
        wr(8'h03, 1, "t5_ptr_ack");
        i2c_bit(1'b1, r); i2c_bit(1'b0, r); i2c_bit(1'b1, r); i2c_bit(1'b0, r);
        i2c_stop();
        w(5);
        check("t5_busy", int'(busy), 0);
        i2c_start();
        wr(8'hD0, 1, "t5_addr2_ack");
        wr(8'h03, 1, "t5_ptr2_ack");
        i2c_start();
        wr(8'hD1, 1, "t5_rd_addr_ack");
        rd(1'b0, 8'h00, "t5_reg3_unchanged");
        i2c_stop();

        // 6) local write colliding with a bus write to reg5: bus wins
        i2c_start();
        wr(8'hD0, 1, "t6_addr_ack");
        wr(8'h05, 1, "t6_ptr_ack");
        exp_wr.push_back(16'h05A5);
        @(negedge clk);
        upd_addr = 5'd5; upd_dat = 8'h77; upd_we = 1'b1;
        seen = 0;
        fork
            wr(8'hA5, 1, "t6_data_ack");
            begin
                for (int k = 0; k < 800 && seen == 0; k++) begin
                    @(posedge clk); #1;
                    if (wr_stb) seen = 1;
                end
                upd_we = 1'b0;
            end
        join
        check("t6_stb_seen", seen, 1);
        i2c_stop();
        // local update mid-read: old byte sent, new value next time
        i2c_start();
        wr(8'hD0, 1, "t6_addr2_ack");
        wr(8'h05, 1, "t6_ptr2_ack");
        i2c_start();
        wr(8'hD1, 1, "t6_rd_addr_ack");
        fork
            rd(1'b0, 8'hA5, "t6_bus_won_old_byte");
            begin
                w(60);
                upd_addr = 5'd5; upd_dat = 8'h3C; upd_we = 1'b1;
                w(1);
                upd_we = 1'b0;
            end
        join
        i2c_stop();
        i2c_start();
        wr(8'hD0, 1, "t6_addr3_ack");
        wr(8'h05, 1, "t6_ptr3_ack");
        i2c_start();
        wr(8'hD1, 1, "t6_rd3_addr_ack");
        rd(1'b0, 8'h3C, "t6_new_byte");
        i2c_stop();

        // 5b) reset during a read while the target drives SDA low (reg0 = BB, bit6 = 0)
        i2c_start();
        wr(8'hD0, 1, "t7_addr_ack");
        wr(8'h00, 1, "t7_ptr_ack");
        i2c_start();
        wr(8'hD1, 1, "t7_rd_addr_ack");
        i2c_bit(1'b1, r);
        check("t7_bit7", int'(r), 1);
        sda_m = 1'b1; w(Q); scl = 1'b1; w(Q);
        check("t7_bit6_driven", int'(sda_oe), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t7_rst_same_clk_release", int'(sda_oe), 0);
        w(3);
        check("t7_rst_busy", int'(busy), 0);
        rst = 1'b0;
        w(3);
        check("t7_sda_oe_after_rst", int'(sda_oe), 0);
        check("t7_wr_addr_after_rst", int'(wr_addr), 0);

        w(20);
        check("exp_bus_drained", exp_q.size(), 0);
        check("exp_wr_drained", exp_wr.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
